// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct encodings and the
// multiply/divide unit's operation and state types.
package mips_pkg;

    localparam logic [5:0] OP_MADDU    = 6'd28;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;

    typedef enum logic {
        MD_MULTU = 1'b0,
        MD_MADDU = 1'b1
    } md_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_shift_add_core.sv
// One-bit-per-cycle shift-add multiplier core: accumulator, multiplier shift
// register, step counter and completion detect (MD_EARLY_TERM_EN adds zero-multiplier exit).
module md_shift_add_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier_shr;

    always_comb begin
        addend     = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
        // product already includes this cycle's partial product
        product    = acc_q + addend;
        mplier_shr = mplier_q >> 1;
`ifdef MD_EARLY_TERM_EN
        last       = (cnt_q == CntW'(WIDTH - 1)) || (mplier_shr == '0);
`else
        last       = (cnt_q == CntW'(WIDTH - 1));
`endif

        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = mcand_in;
            mplier_d = mplier_in;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = product;
            mplier_d = mplier_shr;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/md_hilo_unit.sv
// MULTU/MADDU unit owning HI/LO: control FSM, HI/LO commit, MADDU final add and
// EX-stage stall. Optional MD_EARLY_TERM_EN shortens latency for small multipliers.
module md_hilo_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    md_state_t          state_q, state_d;
    md_op_t             op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               load, step, last;
    logic [2*WIDTH-1:0] product, result;

    md_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .mcand_in  (rs_val),
        .mplier_in (rt_val),
        .product   (product),
        .last      (last)
    );

    always_comb begin
        // MADDU wraps modulo 2^(2*WIDTH); the carry out is dropped
        result  = (op_q == MD_MADDU) ? ({hi_q, lo_q} + product) : product;
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    op_d    = md_op_t'(op);
                    state_d = MD_RUN;
                end
            end
            MD_RUN: begin
                if (abort) begin
                    state_d = MD_IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        {hi_d, lo_d} = result;
                        done_d       = 1'b1;
                        state_d      = MD_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MULTU;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q == MD_RUN);
    assign done  = done_q;
    assign stall = (start | mf_req) & busy;

endmodule

// File: tb/tb_md_hilo_unit.sv
// Self-checking bench for md_hilo_unit: behavioural HI/LO model with per-cycle
// compare, directed literal cases, then randomized traffic.
module tb_md_hilo_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start = 1'b0, op = 1'b0, abort = 1'b0, mf_req = 1'b0;
    logic [W-1:0] rs_val = '0, rt_val = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    md_hilo_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .abort  (abort),
        .mf_req (mf_req),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    // Behavioural model: a countdown of remaining edges plus 64-bit arithmetic
    bit          m_busy, m_done, m_op;
    logic [63:0] m_hilo;
    logic [31:0] m_a, m_b;
    int          m_left;

    function automatic int latency(input logic [31:0] b);
`ifdef MD_EARLY_TERM_EN
        int msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return (msb < 0) ? 1 : msb + 1;
`else
        return 32;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_op = 0; m_hilo = '0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (abort) m_busy = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_op) m_hilo = m_hilo + 64'(m_a) * 64'(m_b);
                        else      m_hilo = 64'(m_a) * 64'(m_b);
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (start && !abort) begin
                m_busy = 1; m_op = op; m_a = rs_val; m_b = rt_val;
                m_left = latency(rt_val);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("hi", 64'(hi), 64'(m_hilo[63:32]));
            check("lo", 64'(lo), 64'(m_hilo[31:0]));
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("stall", 64'(stall), 64'((start | mf_req) & m_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (done) return;
        end
        check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        tick();
        start = 1; op = o; rs_val = a; rt_val = b;
        tick();
        start = 0;
        wait_done(lat);
    endtask

    int lat;
    int exp_lat_6, exp_lat_0;

    initial begin
`ifdef MD_EARLY_TERM_EN
        exp_lat_6 = 3; exp_lat_0 = 1;
`else
        exp_lat_6 = 32; exp_lat_0 = 32;
`endif
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        rst = 0;
        chk_en = 1;

        run_op(1'b0, 32'd7, 32'd6, lat);
        check("multu7x6_lat", 64'(lat), 64'(exp_lat_6));
        check("multu7x6_lo", 64'(lo), 64'd42);
        check("multu7x6_hi", 64'(hi), 64'd0);
        tick();
        check("done_one_cycle", 64'(done), 64'd0);

        run_op(1'b0, 32'd5, 32'd0, lat);
        check("rt0_lat", 64'(lat), 64'(exp_lat_0));
        check("rt0_lo", 64'(lo), 64'd0);

        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        check("max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        run_op(1'b0, 32'hFFFFFFFF, 32'd1, lat);
        check("preload", {hi, lo}, 64'h00000000_FFFFFFFF);
        run_op(1'b1, 32'd1, 32'd1, lat);
        check("maddu_carry", {hi, lo}, 64'h00000001_00000000);

        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        run_op(1'b1, 32'hFFFFFFFE, 32'd1, lat);
        run_op(1'b1, 32'h00010000, 32'h00010000, lat);
        check("all_ones", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        check("maddu_wrap", {hi, lo}, 64'hFFFFFFFE_00000000);

        // MFLO and a second MULTU held in EX while busy
        tick();
        start = 1; op = 0; rs_val = 32'd7; rt_val = 32'd6;
        tick();
        rs_val = 32'd2; rt_val = 32'd3;
        tick();
        mf_req = 1;
        check("stall_busy", 64'(stall), 64'd1);
        wait_done(lat);
        check("mf_lo", 64'(lo), 64'd42);
        check("stall_done_cycle", 64'(stall), 64'd0);
        tick();
        start = 0; mf_req = 0;
        wait_done(lat);
        check("queued_lo", 64'(lo), 64'd6);

        // Abort mid-operation leaves HI/LO untouched
        run_op(1'b0, 32'd4, 32'hC0000001, lat);
        check("pre_abort", {hi, lo}, 64'h00000003_00000004);
        tick();
        start = 1; op = 0; rs_val = 32'd5; rt_val = 32'hFFFFFFFF;
        tick();
        start = 0;
        repeat (9) tick();
        abort = 1;
        tick();
        abort = 0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'h00000003_00000004);
        check("abort_done", 64'(done), 64'd0);
        tick();
        check("abort_no_done", 64'(done), 64'd0);

        // Asynchronous reset mid-operation
        start = 1; op = 1; rs_val = 32'd9; rt_val = 32'hFFFFFFFF;
        tick();
        start = 0;
        repeat (9) tick();
        #2 rst = 1;
        #1;
        check("arst_hilo", {hi, lo}, 64'h0);
        check("arst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst = 0;

        // Randomized traffic, including starts/mf_req while busy and aborts
        for (int c = 0; c < 4000; c++) begin
            tick();
            start  = ($urandom_range(0, 3) == 0);
            op     = 1'($urandom_range(0, 1));
            rs_val = $urandom;
            rt_val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            abort  = ($urandom_range(0, 40) == 0);
            mf_req = ($urandom_range(0, 5) == 0);
        end
        tick();
        start = 0; abort = 0; mf_req = 0;
        repeat (40) tick();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
